mdu_ctrl: RTL and testbench

Multi-cycle multiply/divide unit controller for the 5-stage pipeline, sitting in the E stage beside the ALU. Accepts mult/multu/div/divu/mthi/mtlo from E and sequences a fixed-latency busy period. Owns the architectural HI/LO registers. Produces the MD stall term consumed by the hazard unit to hold D-stage MD instructions while the unit is occupied.

---
 rtl/mdu_ctrl.sv | 144 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for the E stage: owns HI/LO, runs a fixed-latency
// busy period per mult/div and raises the MD stall term for the hazard unit.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_MDOp,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_isMD,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        md_stall
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t         state_q, state_d;
    logic           busy_q, busy_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    hi_q, hi_d, lo_q, lo_d;
    logic [31:0]    pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic           pend_wr_q, pend_wr_d;

    logic [63:0]    sprod, uprod;
    logic [31:0]    abs_a, abs_b, mag_q, mag_r, sdiv_q, sdiv_r, udiv_q, udiv_r;

    assign sprod = $signed(E_A) * $signed(E_B);
    assign uprod = {32'b0, E_A} * {32'b0, E_B};

    // Signed divide built from magnitudes so INT_MIN / -1 wraps to INT_MIN
    // with zero remainder instead of overflowing a signed divider.
    assign abs_a  = E_A[31] ? (~E_A + 32'd1) : E_A;
    assign abs_b  = E_B[31] ? (~E_B + 32'd1) : E_B;
    assign mag_q  = abs_a / abs_b;
    assign mag_r  = abs_a % abs_b;
    assign sdiv_q = (E_A[31] ^ E_B[31]) ? (~mag_q + 32'd1) : mag_q;
    assign sdiv_r = E_A[31] ? (~mag_r + 32'd1) : mag_r;
    assign udiv_q = E_A / E_B;
    assign udiv_r = E_A % E_B;

    assign start    = (state_q == IDLE) && (E_MDOp >= OP_MULT) && (E_MDOp <= OP_DIVU);
    assign busy     = busy_q;
    assign HI       = hi_q;
    assign LO       = lo_q;
    assign md_stall = D_isMD && (start || busy_q);

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            IDLE: begin
                case (E_MDOp)
                    OP_MULT: begin
                        {pend_hi_d, pend_lo_d} = sprod;
                        pend_wr_d = 1'b1;
                        cnt_d     = CW'(MULT_CYCLES);
                    end
                    OP_MULTU: begin
                        {pend_hi_d, pend_lo_d} = uprod;
                        pend_wr_d = 1'b1;
                        cnt_d     = CW'(MULT_CYCLES);
                    end
                    OP_DIV: begin
                        pend_hi_d = sdiv_r;
                        pend_lo_d = sdiv_q;
                        pend_wr_d = (E_B != '0);
                        cnt_d     = CW'(DIV_CYCLES);
                    end
                    OP_DIVU: begin
                        pend_hi_d = udiv_r;
                        pend_lo_d = udiv_q;
                        pend_wr_d = (E_B != '0);
                        cnt_d     = CW'(DIV_CYCLES);
                    end
                    OP_MTHI: hi_d = E_A;
                    OP_MTLO: lo_d = E_A;
                    default: ;
                endcase
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus random ops against a
// 64-bit arithmetic reference model of HI/LO and the busy/stall timing.
module tb_mdu_ctrl;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  E_MDOp;
    logic [31:0] E_A, E_B;
    logic        D_isMD;
    logic        start, busy, md_stall;
    logic [31:0] HI, LO;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .E_MDOp(E_MDOp), .E_A(E_A), .E_B(E_B),
        .D_isMD(D_isMD), .start(start), .busy(busy), .HI(HI), .LO(LO),
        .md_stall(md_stall)
    );

    always #5 clk = ~clk;

    // The hazard unit must never present an MD op while the unit is busy.
    always @(posedge clk) begin
        if (!reset && busy)
            assert (E_MDOp == 3'd0 || E_MDOp == 3'd7)
            else $error("MD op presented while busy");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference result: returns wr=0 when HI/LO must be left untouched.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic wr, output logic [31:0] h, output logic [31:0] l);
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        wr = 1'b1; h = m_hi; l = m_lo;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd1: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            3'd2: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
            3'd3: if (b == 0) wr = 1'b0;
                  else begin sq = sa / sb; sr = sa % sb; l = sq[31:0]; h = sr[31:0]; end
            3'd4: if (b == 0) wr = 1'b0;
                  else begin l = a / b; h = a % b; end
            default: wr = 1'b0;
        endcase
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic dmd);
        logic        is_start, wr;
        logic [31:0] nh, nl;
        int unsigned n;
        is_start = (op >= 3'd1 && op <= 3'd4);
        n = (op <= 3'd2) ? MULT_N : DIV_N;
        model(op, a, b, wr, nh, nl);
        @(negedge clk);
        E_MDOp = op; E_A = a; E_B = b; D_isMD = dmd;
        #1;
        chk("start", start, is_start);
        chk("stall_start", md_stall, dmd && is_start);
        chk("busy_start", busy, 1'b0);
        @(negedge clk);
        E_MDOp = 3'd0; E_A = $urandom; E_B = $urandom;
        #1;
        if (is_start) begin
            for (int i = 0; i < int'(n); i++) begin
                chk("busy_run", busy, 1'b1);
                chk("stall_run", md_stall, dmd);
                chk("start_run", start, 1'b0);
                chk("hi_hold", HI, m_hi);
                chk("lo_hold", LO, m_lo);
                @(negedge clk);
                #1;
            end
            if (wr) begin m_hi = nh; m_lo = nl; end
        end else if (op == 3'd5) begin
            m_hi = a;
        end else if (op == 3'd6) begin
            m_lo = a;
        end
        chk("busy_done", busy, 1'b0);
        chk("stall_done", md_stall, 1'b0);
        chk("hi", HI, m_hi);
        chk("lo", LO, m_lo);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; E_MDOp = '0; E_A = '0; E_B = '0; D_isMD = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_hi", HI, 32'h0);
        chk("rst_lo", LO, 32'h0);
        reset = 1'b0;

        run_op(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b1);
        chk("mult_hi_const", HI, 32'hFFFF_FFFF);
        chk("mult_lo_const", LO, 32'hFFFF_FFF1);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("multu_hi_const", HI, 32'h0000_0001);
        chk("multu_lo_const", LO, 32'hFFFF_FFFE);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
        chk("div_hi_const", HI, 32'hFFFF_FFFF);
        chk("div_lo_const", LO, 32'hFFFF_FFFD);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("divu_hi_const", HI, 32'h0000_0001);
        chk("divu_lo_const", LO, 32'h7FFF_FFFC);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("ovf_hi_const", HI, 32'h0);
        chk("ovf_lo_const", LO, 32'h8000_0000);
        run_op(3'd5, 32'h1234_5678, 32'h0, 1'b1);
        run_op(3'd6, 32'hCAFE_BABE, 32'h0, 1'b0);
        run_op(3'd4, 32'h1111_1111, 32'h0, 1'b1);
        chk("dz_hi_const", HI, 32'h1234_5678);
        chk("dz_lo_const", LO, 32'hCAFE_BABE);
        run_op(3'd7, 32'hDEAD_BEEF, 32'h1, 1'b1);

        for (int k = 0; k < 40; k++)
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 1'($urandom));

        // Reset during busy cycle 3 of a div aborts it with no late writeback.
        @(negedge clk);
        E_MDOp = 3'd3; E_A = 32'd1000; E_B = 32'd7; D_isMD = 1'b0;
        @(negedge clk);
        E_MDOp = 3'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("abort_busy_pre", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_hi", HI, 32'h0);
        chk("abort_lo", LO, 32'h0);
        repeat (DIV_N) @(negedge clk);
        #1;
        chk("late_busy", busy, 1'b0);
        chk("late_hi", HI, 32'h0);
        chk("late_lo", LO, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
